// File: rtl/alu_arbiter.sv
// alu_arbiter: one 16-bit ALU (ADD/SUB/AND/OR with zero and greater flags)
// shared by two requesters. Round-robin grant in IDLE, registered response
// held in RESP until the consumer accepts it, wrapping completion counter.
module alu_arbiter #(
  parameter bit PRIO_RESET = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic [1:0]       req0_op,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [15:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_greater,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t           state_q;
  logic             last_q;      // index of the requester granted most recently
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [15:0]      rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_greater_q;
  logic [CNT_W-1:0] op_count_q;

  logic [1:0]       grant_d;
  logic             sel_d;
  logic [15:0]      alu_a_d;
  logic [15:0]      alu_b_d;
  logic [1:0]       alu_op_d;
  logic [15:0]      alu_res_d;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Datapath: SUB is formed as A + ~B + 1 so all arithmetic wraps modulo 2^16.
  function automatic logic [15:0] alu_calc(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic [1:0]  op);
    logic [15:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a + ~b + 16'h0001;
      2'b10:   r = a & b;
      2'b11:   r = a | b;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Round-robin grant: only in IDLE and never while reset is asserted; a
  // contested cycle goes to the requester that was not granted last.
  always_comb begin
    grant_d = 2'b00;
    if (rst || (state_q != ST_IDLE)) begin
      grant_d = 2'b00;
    end else begin
      case (req_valid)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
        default: grant_d = 2'b00;
      endcase
    end
  end

  // Operand mux: the granted requester's operands feed the shared ALU.
  always_comb begin
    sel_d = grant_d[1];
    if (sel_d) begin
      alu_a_d  = req1_a;
      alu_b_d  = req1_b;
      alu_op_d = req1_op;
    end else begin
      alu_a_d  = req0_a;
      alu_b_d  = req0_b;
      alu_op_d = req0_op;
    end
    alu_res_d = alu_calc(alu_a_d, alu_b_d, alu_op_d);
  end

  // Control FSM with registered response, priority pointer and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= ~PRIO_RESET;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= 16'h0000;
      rsp_zero_q    <= 1'b0;
      rsp_greater_q <= 1'b0;
      op_count_q    <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_d != 2'b00) begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= sel_d;
            last_q        <= sel_d;
            rsp_result_q  <= alu_res_d;
            rsp_zero_q    <= (alu_res_d == 16'h0000);
            rsp_greater_q <= ~alu_res_d[15];
          end else begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_ONE;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = grant_d;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_greater = rsp_greater_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-cycle vectors plus
// hand-written stall, reset-in-RESP and counter-wrap sequences.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_ready;

  logic [1:0]  req_ready, req_ready4;
  logic        rsp_valid, rsp_valid4;
  logic        rsp_id, rsp_id4;
  logic [15:0] rsp_result, rsp_result4;
  logic        rsp_zero, rsp_zero4;
  logic        rsp_greater, rsp_greater4;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.PRIO_RESET(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_greater(rsp_greater), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  alu_arbiter #(.PRIO_RESET(1'b0), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid4), .rsp_id(rsp_id4), .rsp_result(rsp_result4),
    .rsp_zero(rsp_zero4), .rsp_greater(rsp_greater4), .rsp_ready(rsp_ready),
    .op_count(op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] a0, b0;
    logic [1:0]  op0;
    logic [15:0] a1, b1;
    logic [1:0]  op1;
    logic        rrdy;
    logic [1:0]  exp_ready;
    logic        exp_rv;
    logic        exp_id;
    logic [15:0] exp_res;
    logic        exp_zero;
    logic        exp_gt;
  } vec_t;

  vec_t vecs[12];

  task automatic drive(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [1:0] o0, input logic [15:0] a1, input logic [15:0] b1,
                       input logic [1:0] o1, input logic rr);
    req_valid = v;
    req0_a = a0; req0_b = b0; req0_op = o0;
    req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready = rr;
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [15:0] res,
                         input logic z, input logic g);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
    chk({tag, "_rsp_result"}, {16'd0, rsp_result}, {16'd0, res});
    chk({tag, "_rsp_zero"}, {31'd0, rsp_zero}, {31'd0, z});
    chk({tag, "_rsp_greater"}, {31'd0, rsp_greater}, {31'd0, g});
  endtask

  initial begin
    // valid, a0, b0, op0, a1, b1, op1, rsp_ready, exp_ready, rv, id, res, zero, gt
    vecs[0]  = '{2'b01, 16'h0005, 16'h0003, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b1};
    vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 16'h0000, 16'h0000, 2'b00, 16'h0003, 16'h0005, 2'b01, 1'b0, 2'b10, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 16'h1234, 16'h1234, 2'b01, 16'hF0F0, 16'h0FF0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 16'h1234, 16'h1234, 2'b01, 16'hF0F0, 16'h0FF0, 2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{2'b11, 16'h1234, 16'h1234, 2'b01, 16'hF0F0, 16'h0FF0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 16'h8000, 16'h0001, 2'b11, 16'hF0F0, 16'h0FF0, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 16'h00F0, 1'b0, 1'b1};
    vecs[7]  = '{2'b11, 16'h8000, 16'h0001, 2'b11, 16'hFFFF, 16'h0002, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{2'b11, 16'h8000, 16'h0001, 2'b11, 16'hFFFF, 16'h0002, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0};
    vecs[9]  = '{2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 16'h0001, 16'h0001, 2'b00, 16'hFFFF, 16'h0002, 2'b00, 1'b0, 2'b10, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
    vecs[11] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1;
    drive(2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_flags", {30'd0, rsp_zero, rsp_greater}, 32'd0);
    chk("reset_op_count", {16'd0, op_count}, 32'd0);

    // Table: one row per clock, req_ready checked before the edge, rsp_* after.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].op0,
            vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].rrdy);
      #1;
      chk($sformatf("vec%0d_req_ready", i), {30'd0, req_ready}, {30'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].exp_rv});
      if (vecs[i].exp_rv) begin
        chk_rsp($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_res,
                vecs[i].exp_zero, vecs[i].exp_gt);
      end
    end
    chk("table_op_count", {16'd0, op_count}, 32'd6);

    // Stall: response held for 3 cycles with both requesters waiting.
    @(negedge clk);
    drive(2'b11, 16'h0100, 16'h0020, 2'b00, 16'h0007, 16'h0007, 2'b01, 1'b0);
    #1;
    chk("stall_accept_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_req_ready", c), {30'd0, req_ready}, 32'd0);
      chk_rsp($sformatf("stall%0d", c), 1'b0, 16'h0120, 1'b0, 1'b1);
      chk($sformatf("stall%0d_op_count", c), {16'd0, op_count}, 32'd6);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("stall_release_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stall_release_count", {16'd0, op_count}, 32'd7);

    // Reset while RESP: held response discarded, pointer back to PRIO_RESET.
    @(negedge clk);
    drive(2'b11, 16'h0100, 16'h0020, 2'b00, 16'h0009, 16'h0001, 2'b00, 1'b0);
    #1;
    chk("rstresp_accept_ready", {30'd0, req_ready}, 32'd2);
    @(posedge clk);
    #1;
    chk_rsp("rstresp_pre", 1'b1, 16'h000A, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("rstresp_ready_in_reset", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstresp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstresp_rsp_result", {16'd0, rsp_result}, 32'd0);
    chk("rstresp_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rstresp_op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("rstresp_prio_grant", {30'd0, req_ready}, 32'd1);

    // Counter wrap on the 4-bit instance: 16 handshakes from reset.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive(2'b01, k[15:0], 16'h0001, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0);
      #1;
      if (k == 1) chk("wrap_ready4", {30'd0, req_ready4}, 32'd1);
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("wrap_rsp_valid4", {31'd0, rsp_valid4}, 32'd1);
        chk("wrap_rsp_id4", {31'd0, rsp_id4}, 32'd0);
        chk("wrap_rsp_result4", {16'd0, rsp_result4}, 32'd2);
        chk("wrap_flags4", {30'd0, rsp_zero4, rsp_greater4}, 32'd1);
      end
      @(negedge clk);
      drive(2'b00, 16'h0000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1);
      @(posedge clk);
      #1;
      if (k == 15) chk("wrap_count4_at15", {28'd0, op_count4}, 32'd15);
      if (k == 16) begin
        chk("wrap_count4_at16", {28'd0, op_count4}, 32'd0);
        chk("wrap_count16_at16", {16'd0, op_count}, 32'd16);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
